// File: rtl/easyaxi_rd_mst.sv
// AXI4 read master: issues REQ_NUM fixed-length INCR bursts one at a time,
// XOR-accumulates the returned data and keeps a sticky protocol/response error flag.
module easyaxi_rd_mst #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    BURST_LEN  = 3,
    parameter int                    REQ_NUM    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0000_1000)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  axi_mst_arvalid,
    input  logic                  axi_mst_arready,
    output logic [ADDR_WIDTH-1:0] axi_mst_araddr,
    output logic [ID_WIDTH-1:0]   axi_mst_arid,
    output logic [7:0]            axi_mst_arlen,
    output logic [2:0]            axi_mst_arsize,
    output logic [1:0]            axi_mst_arburst,
    input  logic                  axi_mst_rvalid,
    output logic                  axi_mst_rready,
    input  logic [DATA_WIDTH-1:0] axi_mst_rdata,
    input  logic [1:0]            axi_mst_rresp,
    input  logic                  axi_mst_rlast,
    input  logic [ID_WIDTH-1:0]   axi_mst_rid,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rd_sum
);
    localparam int               CNT_W       = ID_WIDTH + 1;
    localparam int               BURST_BYTES = (BURST_LEN + 1) * (DATA_WIDTH / 8);
    localparam logic [2:0]       AR_SIZE     = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
    localparam logic [7:0]       LAST_BEAT   = 8'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_REQ    = CNT_W'(REQ_NUM - 1);

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_req_cnt;
    logic [7:0]            r_beat_cnt;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rd_sum;
    logic                  w_ar_hs;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_burst_end;
    logic                  w_beat_err;

    assign w_ar_hs     = (r_state == AR) && axi_mst_arready;
    assign w_beat      = (r_state == R) && axi_mst_rvalid;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    // The burst length is fixed, so rlast must match the beat counter exactly.
    assign w_burst_end = w_beat && w_last_beat;
    assign w_beat_err  = (axi_mst_rresp != 2'b00)
                      || (axi_mst_rid != r_req_cnt[ID_WIDTH-1:0])
                      || (axi_mst_rlast != w_last_beat);

    // AR fields derive from registered state only, so they stay stable while stalled.
    assign axi_mst_arvalid = (r_state == AR);
    assign axi_mst_rready  = (r_state == R);
    assign done            = (r_state == DONE);
    assign axi_mst_araddr  = BASE_ADDR + ADDR_WIDTH'(r_req_cnt) * ADDR_WIDTH'(BURST_BYTES);
    assign axi_mst_arid    = r_req_cnt[ID_WIDTH-1:0];
    assign axi_mst_arlen   = LAST_BEAT;
    assign axi_mst_arsize  = AR_SIZE;
    assign axi_mst_arburst = 2'b01;
    assign err             = r_err;
    assign rd_sum          = r_rd_sum;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (enable) w_state_nxt = AR;
            AR:   if (axi_mst_arready) w_state_nxt = R;
            R: begin
                if (w_burst_end) begin
                    if (r_req_cnt == LAST_REQ) w_state_nxt = DONE;
                    else if (enable)           w_state_nxt = AR;
                    else                       w_state_nxt = IDLE;
                end
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_cnt  <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_rd_sum   <= '0;
        end else begin
            if (w_ar_hs) begin
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (w_burst_end) begin
                r_req_cnt <= r_req_cnt + CNT_W'(1);
            end
            if (w_beat) begin
                r_rd_sum <= r_rd_sum ^ axi_mst_rdata;
                if (w_beat_err) r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_easyaxi_rd_mst.sv
// Directed bench for easyaxi_rd_mst: a scripted slave answers each AR, while a queue
// of expected AR beats and a data/error model supply every reference value.
module tb_easyaxi_rd_mst;
    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        axi_mst_arvalid;
    logic        axi_mst_arready;
    logic [31:0] axi_mst_araddr;
    logic [3:0]  axi_mst_arid;
    logic [7:0]  axi_mst_arlen;
    logic [2:0]  axi_mst_arsize;
    logic [1:0]  axi_mst_arburst;
    logic        axi_mst_rvalid;
    logic        axi_mst_rready;
    logic [31:0] axi_mst_rdata;
    logic [1:0]  axi_mst_rresp;
    logic        axi_mst_rlast;
    logic [3:0]  axi_mst_rid;
    logic        done;
    logic        err;
    logic [31:0] rd_sum;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
    } ar_exp_t;

    ar_exp_t     sb_ar[$];
    logic [31:0] exp_sum;
    logic        exp_err;
    logic [3:0]  cur_id;
    int          n_vec;
    int          n_err;
    int          n_hs;
    int          n_beats;

    easyaxi_rd_mst dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .axi_mst_arvalid (axi_mst_arvalid),
        .axi_mst_arready (axi_mst_arready),
        .axi_mst_araddr  (axi_mst_araddr),
        .axi_mst_arid    (axi_mst_arid),
        .axi_mst_arlen   (axi_mst_arlen),
        .axi_mst_arsize  (axi_mst_arsize),
        .axi_mst_arburst (axi_mst_arburst),
        .axi_mst_rvalid  (axi_mst_rvalid),
        .axi_mst_rready  (axi_mst_rready),
        .axi_mst_rdata   (axi_mst_rdata),
        .axi_mst_rresp   (axi_mst_rresp),
        .axi_mst_rlast   (axi_mst_rlast),
        .axi_mst_rid     (axi_mst_rid),
        .done            (done),
        .err             (err),
        .rd_sum          (rd_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (axi_mst_arvalid && axi_mst_arready) n_hs++;
        if (axi_mst_rvalid && axi_mst_rready)   n_beats++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_arvalid"}, axi_mst_arvalid, 1'b0);
        check({tag, "_rready"},  axi_mst_rready,  1'b0);
        check({tag, "_araddr"},  axi_mst_araddr,  32'h0000_1000);
        check({tag, "_arid"},    axi_mst_arid,    4'd0);
        check({tag, "_arlen"},   axi_mst_arlen,   8'd3);
        check({tag, "_arsize"},  axi_mst_arsize,  3'd2);
        check({tag, "_arburst"}, axi_mst_arburst, 2'b01);
        check({tag, "_done"},    done,            1'b0);
        check({tag, "_err"},     err,             1'b0);
        check({tag, "_rd_sum"},  rd_sum,          32'h0);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        enable          = 1'b0;
        axi_mst_arready = 1'b1;
        axi_mst_rvalid  = 1'b0;
        axi_mst_rdata   = '0;
        axi_mst_rresp   = 2'b00;
        axi_mst_rlast   = 1'b0;
        axi_mst_rid     = '0;
        sb_ar.delete();
        exp_sum = '0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_session();
        for (int k = 0; k < 4; k++) begin
            ar_exp_t e;
            e.addr = 32'h0000_1000 + 32'(k * 16);
            e.id   = 4'(k);
            sb_ar.push_back(e);
        end
        enable = 1'b1;
    endtask

    // Wait for arvalid, optionally stall arready (and drop enable meanwhile), then handshake.
    task automatic ar_phase(input int stall, input bit drop_en);
        ar_exp_t e;
        int      k;
        int      hs0;
        e = sb_ar.pop_front();
        if (stall > 0) axi_mst_arready = 1'b0;
        k = 0;
        while (!axi_mst_arvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ar_wait_arvalid", axi_mst_arvalid, 1'b1);
        if (!axi_mst_arvalid) return;
        check("araddr",  axi_mst_araddr,  e.addr);
        check("arid",    axi_mst_arid,    e.id);
        check("arlen",   axi_mst_arlen,   8'd3);
        check("arsize",  axi_mst_arsize,  3'd2);
        check("arburst", axi_mst_arburst, 2'b01);
        hs0 = n_hs;
        for (int c = 0; c < stall; c++) begin
            if (drop_en && c == 1) enable = 1'b0;
            @(negedge clk);
            check("stall_arvalid", axi_mst_arvalid, 1'b1);
            check("stall_araddr",  axi_mst_araddr,  e.addr);
            check("stall_arid",    axi_mst_arid,    e.id);
        end
        if (drop_en) enable = 1'b1;
        axi_mst_arready = 1'b1;
        @(negedge clk);
        check("ar_handshakes", n_hs - hs0, 1);
        check("ar_arvalid_low", axi_mst_arvalid, 1'b0);
        check("ar_rready_high", axi_mst_rready, 1'b1);
        cur_id = e.id;
    endtask

    // Four beats back to back; beat-index arguments < 0 disable that fault.
    task automatic r_burst(input bit rnd, input int bad_resp_beat, input int early_last_beat,
                           input int bad_id_beat, input bit no_last, input int drop_en_beat);
        logic [31:0] d;
        logic        bad;
        for (int b = 0; b < 4; b++) begin
            check("r_err_before_beat", err, exp_err);
            check("r_rready", axi_mst_rready, 1'b1);
            d = rnd ? 32'($urandom) : 32'(b);
            axi_mst_rvalid = 1'b1;
            axi_mst_rdata  = d;
            axi_mst_rresp  = (b == bad_resp_beat) ? 2'b10 : 2'b00;
            axi_mst_rid    = (b == bad_id_beat) ? (cur_id ^ 4'h1) : cur_id;
            axi_mst_rlast  = ((b == 3) && !no_last) || (b == early_last_beat);
            bad = (axi_mst_rresp != 2'b00) || (axi_mst_rid != cur_id)
               || (axi_mst_rlast && b < 3) || (!axi_mst_rlast && b == 3);
            if (b == drop_en_beat) enable = 1'b0;
            @(posedge clk);
            if (axi_mst_rready) begin
                exp_sum = exp_sum ^ d;
                if (bad) exp_err = 1'b1;
            end
            @(negedge clk);
        end
        axi_mst_rvalid = 1'b0;
        axi_mst_rlast  = 1'b0;
        check("r_err_after_burst", err, exp_err);
        check("r_rd_sum", rd_sum, exp_sum);
        check("r_rready_end", axi_mst_rready, 1'b0);
    endtask

    initial begin
        int beats0;
        n_vec   = 0;
        n_err   = 0;
        n_hs    = 0;
        n_beats = 0;
        cur_id  = '0;

        // Basic session: four clean bursts, beat-index data.
        do_reset();
        beats0 = n_beats;
        start_session();
        for (int k = 0; k < 4; k++) begin
            ar_phase(0, 1'b0);
            r_burst(1'b0, -1, -1, -1, 1'b0, -1);
        end
        check("t1_beats", n_beats - beats0, 16);
        check("t1_done", done, 1'b1);
        check("t1_err", err, 1'b0);
        check("t1_rd_sum", rd_sum, 32'h0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_done_held", done, 1'b1);
        check("t1_no_new_ar", axi_mst_arvalid, 1'b0);

        // arready stalled 5 cycles on the second AR, enable dropping during the stall.
        do_reset();
        start_session();
        ar_phase(0, 1'b0);
        r_burst(1'b1, -1, -1, -1, 1'b0, -1);
        ar_phase(5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            r_burst(1'b1, -1, -1, -1, 1'b0, -1);
            if (k < 2) ar_phase(0, 1'b0);
        end
        check("t2_done", done, 1'b1);
        check("t2_err", err, 1'b0);

        // SLVERR on beat 1 of the third burst.
        do_reset();
        start_session();
        for (int k = 0; k < 4; k++) begin
            ar_phase(0, 1'b0);
            r_burst(1'b1, (k == 2) ? 1 : -1, -1, -1, 1'b0, -1);
        end
        check("t3_done", done, 1'b1);
        check("t3_err", err, 1'b1);

        // Early rlast on beat 2 of the first burst.
        do_reset();
        start_session();
        ar_phase(0, 1'b0);
        r_burst(1'b0, -1, 2, -1, 1'b0, -1);
        ar_phase(0, 1'b0);
        check("t4_err", err, 1'b1);

        // enable drops during burst 1, resume later; missing rlast on the final burst.
        do_reset();
        start_session();
        ar_phase(0, 1'b0);
        r_burst(1'b1, -1, -1, -1, 1'b0, -1);
        ar_phase(0, 1'b0);
        r_burst(1'b1, -1, -1, -1, 1'b0, 1);
        for (int c = 0; c < 3; c++) begin
            check("t5_idle_arvalid", axi_mst_arvalid, 1'b0);
            check("t5_idle_rready", axi_mst_rready, 1'b0);
            @(negedge clk);
        end
        enable = 1'b1;
        ar_phase(0, 1'b0);
        r_burst(1'b1, -1, -1, -1, 1'b0, -1);
        ar_phase(0, 1'b0);
        check("t5_err_before_last", err, 1'b0);
        r_burst(1'b1, -1, -1, -1, 1'b1, -1);
        check("t5_done", done, 1'b1);

        // Bad rid in burst 0, then reset pulsed mid burst 2.
        do_reset();
        start_session();
        ar_phase(0, 1'b0);
        r_burst(1'b1, -1, -1, 2, 1'b0, -1);
        ar_phase(0, 1'b0);
        r_burst(1'b1, -1, -1, -1, 1'b0, -1);
        ar_phase(0, 1'b0);
        axi_mst_rvalid = 1'b1;
        axi_mst_rdata  = 32'hDEAD_BEEF;
        axi_mst_rresp  = 2'b00;
        axi_mst_rid    = cur_id;
        axi_mst_rlast  = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("t6_async");
        do_reset();
        start_session();
        ar_phase(0, 1'b0);
        check("t6_sum_restart", rd_sum, 32'h0);
        for (int k = 0; k < 4; k++) begin
            r_burst(1'b1, -1, -1, -1, 1'b0, -1);
            if (k < 3) ar_phase(0, 1'b0);
        end
        check("t6_done", done, 1'b1);
        check("t6_err", err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
